// File: rtl/cpu_pipe_pkg.sv
// Shared types for CPU pipeline stage registers: occupancy encoding and the
// payload layouts that callers pack into a stage's data bus.
package cpu_pipe_pkg;

  localparam int DEFAULT_DATA_W = 32;

  typedef logic [1:0] occ_t;

  typedef enum occ_t {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_FULL  = 2'd2
  } occ_e;

  typedef struct packed {
    logic        interrupt;
    logic        interrupt_mask;
    logic [31:0] pc_plus_4;
    logic [31:0] instr;
  } if_id_t;

  localparam int IF_ID_W = $bits(if_id_t);

endpackage

// File: rtl/pipe_slot.sv
// One payload register with its valid bit. Flush and reset restore RESET_VAL;
// a plain clear only drops valid so the last payload stays visible.
module pipe_slot #(
  parameter int                DATA_W    = 32,
  parameter logic [DATA_W-1:0] RESET_VAL = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              load,
  input  logic              clear,
  input  logic [DATA_W-1:0] d,
  output logic [DATA_W-1:0] q,
  output logic              valid
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q     <= RESET_VAL;
      valid <= 1'b0;
    end else if (flush) begin
      q     <= RESET_VAL;
      valid <= 1'b0;
    end else if (load) begin
      q     <= d;
      valid <= 1'b1;
    end else if (clear) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/pipe_stage_reg.sv
// Handshaked pipeline stage register. SKID=1 adds an overflow slot so in_ready
// comes straight from a flop; SKID=0 is a single slot with pass-through ready.
module pipe_stage_reg
  import cpu_pipe_pkg::*;
#(
  parameter int                DATA_W    = DEFAULT_DATA_W,
  parameter bit                SKID      = 1'b1,
  parameter logic [DATA_W-1:0] RESET_VAL = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy
);

  logic              in_fire;
  logic              out_fire;
  logic              main_load;
  logic              main_clear;
  logic [DATA_W-1:0] main_d;
  logic              main_valid;

  assign in_fire   = in_valid && in_ready;
  assign out_fire  = main_valid && out_ready;
  assign out_valid = main_valid;

  pipe_slot #(
    .DATA_W    (DATA_W),
    .RESET_VAL (RESET_VAL)
  ) u_main (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .load  (main_load),
    .clear (main_clear),
    .d     (main_d),
    .q     (out_data),
    .valid (main_valid)
  );

  generate
    if (SKID) begin : g_skid
      occ_e              state;
      logic              skid_load;
      logic              skid_clear;
      logic              skid_valid;
      logic [DATA_W-1:0] skid_q;

      pipe_slot #(
        .DATA_W    (DATA_W),
        .RESET_VAL (RESET_VAL)
      ) u_skid (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush),
        .load  (skid_load),
        .clear (skid_clear),
        .d     (in_data),
        .q     (skid_q),
        .valid (skid_valid)
      );

      // Ready is the complement of a flop, so no path from out_ready.
      assign in_ready  = !skid_valid;
      assign occupancy = occ_t'(state);

      always_comb begin
        main_load  = 1'b0;
        main_clear = 1'b0;
        main_d     = in_data;
        skid_load  = 1'b0;
        skid_clear = 1'b0;
        case (state)
          OCC_EMPTY: main_load = in_fire;
          OCC_ONE: begin
            if (in_fire && out_fire) main_load  = 1'b1;
            else if (in_fire)        skid_load  = 1'b1;
            else if (out_fire)       main_clear = 1'b1;
          end
          OCC_FULL: begin
            if (out_fire) begin
              main_load  = 1'b1;
              main_d     = skid_q;
              skid_clear = 1'b1;
            end
          end
          default: ;
        endcase
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          state <= OCC_EMPTY;
        end else if (flush) begin
          state <= OCC_EMPTY;
        end else begin
          case (state)
            OCC_EMPTY: if (in_fire) state <= OCC_ONE;
            OCC_ONE: begin
              if (in_fire && !out_fire)      state <= OCC_FULL;
              else if (out_fire && !in_fire) state <= OCC_EMPTY;
            end
            OCC_FULL:  if (out_fire) state <= OCC_ONE;
            default:   state <= OCC_EMPTY;
          endcase
        end
      end
    end else begin : g_single
      assign in_ready  = !main_valid || out_ready;
      assign occupancy = {1'b0, main_valid};

      always_comb begin
        main_d     = in_data;
        main_load  = in_fire;
        main_clear = out_fire && !in_fire;
      end
    end
  endgenerate

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg: one SKID=1 and one SKID=0 instance share
// the stimulus; each phase checks the instance it targets.
module tb_pipe_stage_reg;

  localparam int          DW    = 8;
  localparam logic [7:0]  RV_S  = 8'h5A;
  localparam logic [7:0]  RV_N  = 8'hA5;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          flush;
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic          out_ready;

  logic          s_in_ready, s_out_valid;
  logic [DW-1:0] s_out_data;
  logic [1:0]    s_occ;
  logic          n_in_ready, n_out_valid;
  logic [DW-1:0] n_out_data;
  logic [1:0]    n_occ;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  pipe_stage_reg #(.DATA_W(DW), .SKID(1'b1), .RESET_VAL(RV_S)) u_skid (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(s_in_ready), .in_data(in_data),
    .out_valid(s_out_valid), .out_ready(out_ready), .out_data(s_out_data),
    .occupancy(s_occ)
  );

  pipe_stage_reg #(.DATA_W(DW), .SKID(1'b0), .RESET_VAL(RV_N)) u_single (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(n_in_ready), .in_data(in_data),
    .out_valid(n_out_valid), .out_ready(out_ready), .out_data(n_out_data),
    .occupancy(n_occ)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_s(input string tag, input logic v, input logic [7:0] d,
                       input logic r, input logic [1:0] o);
    chk({tag, ".out_valid"}, 32'(s_out_valid), 32'(v));
    chk({tag, ".out_data"},  32'(s_out_data),  32'(d));
    chk({tag, ".in_ready"},  32'(s_in_ready),  32'(r));
    chk({tag, ".occupancy"}, 32'(s_occ),       32'(o));
  endtask

  int next_in;
  int exp_out;
  int delivered;

  initial begin
    rst_n = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk_s("rst_s", 1'b0, RV_S, 1'b1, 2'd0);
    chk("rst_n.out_data", 32'(n_out_data), 32'(RV_N));
    #19 rst_n = 1'b1;

    for (int i = 0; i < 5; i++) begin
      tick();
      chk_s("idle", 1'b0, RV_S, 1'b1, 2'd0);
    end

    // streaming 1,2,3 with out_ready high
    tick(); in_valid = 1'b1; in_data = 8'h01; out_ready = 1'b1;
    #1 chk("stream.in_ready", 32'(s_in_ready), 32'd1);
    for (int k = 2; k <= 4; k++) begin
      tick();
      if (k <= 3) in_data = 8'(k); else in_valid = 1'b0;
      #1 chk_s("stream", 1'b1, 8'(k - 1), 1'b1, 2'd1);
    end
    tick(); #1 chk_s("drain", 1'b0, 8'h03, 1'b1, 2'd0);

    // stall: A, B, C with out_ready low
    tick(); in_valid = 1'b1; in_data = 8'h0A; out_ready = 1'b0;
    tick(); in_data = 8'h0B;
    #1 chk_s("stall1", 1'b1, 8'h0A, 1'b1, 2'd1);
    tick(); in_data = 8'h0C;
    #1 chk_s("stall2", 1'b1, 8'h0A, 1'b0, 2'd2);
    tick(); out_ready = 1'b1;
    #1 chk_s("stall_hold", 1'b1, 8'h0A, 1'b0, 2'd2);
    tick(); #1 chk_s("release_b", 1'b1, 8'h0B, 1'b1, 2'd1);
    tick(); in_valid = 1'b0;
    #1 chk_s("release_c", 1'b1, 8'h0C, 1'b1, 2'd1);
    tick(); #1 chk_s("release_end", 1'b0, 8'h0C, 1'b1, 2'd0);

    // flush from FULL with 0xD offered
    tick(); in_valid = 1'b1; in_data = 8'h01; out_ready = 1'b0;
    tick(); in_data = 8'h02;
    tick(); in_data = 8'h0D; flush = 1'b1;
    #1 chk("flush_full.occ", 32'(s_occ), 32'd2);
    tick(); flush = 1'b0; in_valid = 1'b0;
    #1 chk_s("flush_full", 1'b0, RV_S, 1'b1, 2'd0);
    tick(); #1 chk_s("flush_after", 1'b0, RV_S, 1'b1, 2'd0);

    // flush from ONE while an in_fire of 0xF happens
    in_valid = 1'b1; in_data = 8'h0E;
    tick(); in_data = 8'h0F; flush = 1'b1;
    #1 chk_s("flush_one_pre", 1'b1, 8'h0E, 1'b1, 2'd1);
    tick(); flush = 1'b0; in_valid = 1'b0;
    #1 chk_s("flush_one", 1'b0, RV_S, 1'b1, 2'd0);
    chk("flush_one.single_valid", 32'(n_out_valid), 32'd0);

    // async reset while FULL
    tick(); in_valid = 1'b1; in_data = 8'h07; out_ready = 1'b0;
    tick(); in_data = 8'h08;
    tick(); in_valid = 1'b0;
    #1 chk_s("pre_areset", 1'b1, 8'h07, 1'b0, 2'd2);
    #2 rst_n = 1'b0;
    #1 chk_s("areset", 1'b0, RV_S, 1'b1, 2'd0);
    chk("areset.single_data", 32'(n_out_data), 32'(RV_N));
    #2 rst_n = 1'b1;

    // SKID=0: out_ready toggles, in_valid constant, payload advances on accept
    next_in = 1; exp_out = 1; delivered = 0;
    tick();
    in_valid = 1'b1;
    for (int c = 0; c < 20; c++) begin
      out_ready = (c % 2 == 0);
      in_data = 8'(next_in);
      #1;
      chk("single.in_ready", 32'(n_in_ready), 32'(!n_out_valid || out_ready));
      if (n_out_valid && out_ready) begin
        chk("single.out_data", 32'(n_out_data), 32'(exp_out));
        exp_out++;
        delivered++;
      end
      if (n_in_ready) next_in++;
      tick();
    end
    in_valid = 1'b0;
    chk("single.delivered", 32'(delivered), 32'd9);
    chk("single.occ", 32'(n_occ), 32'd1);
    chk("single.held", 32'(n_out_data), 32'd10);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
